alu_uart_interface: RTL and testbench
=====================================

Name: alu_uart_interface

Overview:
Frame-assembly and dispatch stage between the UART receiver and the ALU, inside TOP. It collects three received bytes in order: operand A, operand B, opcode. It presents them to the combinational ALU, captures the result and hands it to the UART transmitter as a single byte. It also resynchronises framing after line silence or an illegal opcode.

Parameters:
N_BITS_DATA, 8, width of operands, result and UART byte
N_BITS_OP, 6, opcode width (low bits of the third byte)
TIMEOUT_CYCLES, 100000, idle clock cycles allowed between bytes of one frame before the frame is discarded; counter width = $clog2(TIMEOUT_CYCLES)

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
rx_done_tick_i  in  1  one-cycle pulse from the UART receiver: rx_data_i is valid
rx_data_i  in  N_BITS_DATA  received byte
alu_result_i  in  N_BITS_DATA  combinational ALU output for data_a_o/data_b_o/op_o
tx_done_tick_i  in  1  one-cycle pulse from the UART transmitter: byte sent
data_a_o  out  N_BITS_DATA  registered operand A to the ALU
data_b_o  out  N_BITS_DATA  registered operand B to the ALU
op_o  out  N_BITS_OP  registered opcode to the ALU
tx_start_o  out  1  one-cycle start pulse to the UART transmitter
tx_data_o  out  N_BITS_DATA  registered byte to transmit
frame_err_o  out  1  one-cycle pulse when a frame is discarded
busy_o  out  1  high in EXEC, SEND and WAIT_TX

Behaviour:
- Reset (reset=0, asynchronous): state=WAIT_A; data_a_o, data_b_o, op_o, tx_data_o = 0; tx_start_o=0, frame_err_o=0, busy_o=0; timeout counter=0. Reset mid-frame or mid-transmit abandons everything, and the next rx byte is taken as A.
- Legal opcodes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 000011 SRA, 000010 SRL, 100111 NOR. Byte bits [7:6] are ignored.
- FSM states:
  - WAIT_A: on rx_done_tick_i, load data_a_o=rx_data_i, clear the counter, go to WAIT_B.
  - WAIT_B: on a tick, load data_b_o, clear the counter, go to WAIT_OP.
  - WAIT_OP: on a tick with a legal opcode, load op_o and go to EXEC. With an illegal opcode, leave op_o unchanged, pulse frame_err_o next cycle and go to WAIT_A.
  - EXEC (1 cycle): ALU settles; at the edge, tx_data_o <= alu_result_i; go to SEND.
  - SEND (1 cycle): tx_start_o=1; go to WAIT_TX.
  - WAIT_TX: hold until tx_done_tick_i, then go to WAIT_A.
- Latency: if the opcode tick is in cycle n, op_o is valid from n+1, tx_data_o is valid from n+2, and tx_start_o is high in cycle n+2 only.
- tx_start_o and frame_err_o are registered, never combinational, and exactly one cycle wide.
- Timeout: the counter runs only in WAIT_B and WAIT_OP, incrementing each cycle without a tick. On the cycle it reaches TIMEOUT_CYCLES-1, go to WAIT_A and pulse frame_err_o. data_a_o and data_b_o hold their stale values.
- A tick in the same cycle as timeout expiry: the byte wins. It is accepted normally and no error is raised.
- rx_done_tick_i in EXEC, SEND or WAIT_TX is dropped, with no error and no state change.
- tx_done_tick_i outside WAIT_TX is ignored.
- Operands and results are plain N_BITS_DATA-bit vectors; the block does no arithmetic and no sign handling.

Test Plan:
- Use an ALU stub computing ADD. Send bytes 0x07, 0x03, 0x20 → data_a_o=0x07, data_b_o=0x03, op_o=0x20. tx_data_o=0x0A, tx_start_o high for exactly one cycle, 2 cycles after the opcode tick. busy_o stays high until tx_done_tick_i, then returns to 0.
- Send 0x05, 0x01, then illegal opcode 0x3F → frame_err_o pulses once, no tx_start_o, state WAIT_A. Next 0x11 loads data_a_o=0x11.
- With TIMEOUT_CYCLES=64, send 0x22 and then nothing for 64 cycles → frame_err_o pulses once. A following 0x33 loads data_a_o, not data_b_o.
- With TIMEOUT_CYCLES=64, send 0x22, then the next tick on exactly cycle 63 → accepted as B, no frame_err_o.
- Deliver an extra rx tick (0x99) while in WAIT_TX → data_a_o unchanged, no error. After tx_done_tick_i, the next tick loads A.
- Assert reset=0 asynchronously (mid-clock) in WAIT_OP after A=0x44, B=0x55 → all outputs 0 immediately. After release, bytes 0x01, 0x02, 0x20 produce a normal frame with tx_data_o=0x03.

Source files
------------

// File: rtl/alu_uart_interface.sv
// Frame assembler between the UART receiver and the ALU: collects A, B and opcode bytes,
// launches one result byte to the UART transmitter and recovers framing on timeout or bad opcode.
module alu_uart_interface #(
   parameter int unsigned N_BITS_DATA    = 8,
   parameter int unsigned N_BITS_OP      = 6,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   rx_done_tick_i,
   input  logic [N_BITS_DATA-1:0] rx_data_i,
   input  logic [N_BITS_DATA-1:0] alu_result_i,
   input  logic                   tx_done_tick_i,
   output logic [N_BITS_DATA-1:0] data_a_o,
   output logic [N_BITS_DATA-1:0] data_b_o,
   output logic [N_BITS_OP-1:0]   op_o,
   output logic                   tx_start_o,
   output logic [N_BITS_DATA-1:0] tx_data_o,
   output logic                   frame_err_o,
   output logic                   busy_o
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   localparam logic [N_BITS_OP-1:0] OpAdd = N_BITS_OP'(6'b100000);
   localparam logic [N_BITS_OP-1:0] OpSub = N_BITS_OP'(6'b100010);
   localparam logic [N_BITS_OP-1:0] OpAnd = N_BITS_OP'(6'b100100);
   localparam logic [N_BITS_OP-1:0] OpOr  = N_BITS_OP'(6'b100101);
   localparam logic [N_BITS_OP-1:0] OpXor = N_BITS_OP'(6'b100110);
   localparam logic [N_BITS_OP-1:0] OpSra = N_BITS_OP'(6'b000011);
   localparam logic [N_BITS_OP-1:0] OpSrl = N_BITS_OP'(6'b000010);
   localparam logic [N_BITS_OP-1:0] OpNor = N_BITS_OP'(6'b100111);

   typedef enum logic [2:0] {
      StWaitA,
      StWaitB,
      StWaitOp,
      StExec,
      StSend,
      StWaitTx
   } state_e;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [N_BITS_DATA-1:0] a_q, a_d;
   logic [N_BITS_DATA-1:0] b_q, b_d;
   logic [N_BITS_OP-1:0]   op_q, op_d;
   logic [N_BITS_DATA-1:0] tx_data_q, tx_data_d;
   logic                   tx_start_q, tx_start_d;
   logic                   err_q, err_d;
   logic [N_BITS_OP-1:0]   rx_op;
   logic                   op_legal;
   logic                   expired;

   assign rx_op   = rx_data_i[N_BITS_OP-1:0];
   assign expired = (cnt_q == CntLast);

   always_comb begin
      unique case (rx_op)
         OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSra, OpSrl, OpNor: op_legal = 1'b1;
         default:                                               op_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      err_d      = 1'b0;
      unique case (state_q)
         StWaitA: begin
            if (rx_done_tick_i) begin
               a_d     = rx_data_i;
               cnt_d   = '0;
               state_d = StWaitB;
            end
         end
         StWaitB: begin
            // A byte arriving on the expiry cycle takes priority over the timeout.
            if (rx_done_tick_i) begin
               b_d     = rx_data_i;
               cnt_d   = '0;
               state_d = StWaitOp;
            end else if (expired) begin
               cnt_d   = '0;
               err_d   = 1'b1;
               state_d = StWaitA;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StWaitOp: begin
            if (rx_done_tick_i) begin
               cnt_d = '0;
               if (op_legal) begin
                  op_d    = rx_op;
                  state_d = StExec;
               end else begin
                  err_d   = 1'b1;
                  state_d = StWaitA;
               end
            end else if (expired) begin
               cnt_d   = '0;
               err_d   = 1'b1;
               state_d = StWaitA;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StExec: begin
            tx_data_d  = alu_result_i;
            tx_start_d = 1'b1;
            state_d    = StSend;
         end
         StSend: begin
            state_d = StWaitTx;
         end
         StWaitTx: begin
            if (tx_done_tick_i) begin
               state_d = StWaitA;
            end
         end
         default: begin
            state_d = StWaitA;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= StWaitA;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         err_q      <= err_d;
      end
   end

   assign data_a_o    = a_q;
   assign data_b_o    = b_q;
   assign op_o        = op_q;
   assign tx_data_o   = tx_data_q;
   assign tx_start_o  = tx_start_q;
   assign frame_err_o = err_q;
   assign busy_o      = (state_q == StExec) || (state_q == StSend) || (state_q == StWaitTx);

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: directed framing cases plus random frames against a
// frame-level model, using an ADD-only ALU stub.
module tb_alu_uart_interface;

   localparam int unsigned T = 64;

   logic       clock = 1'b0;
   logic       reset;
   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic [7:0] alu_result;
   logic       tx_done_tick;
   logic [7:0] data_a, data_b, tx_data;
   logic [5:0] op;
   logic       tx_start, frame_err, busy;

   int checks   = 0;
   int failures = 0;
   int n_start  = 0;
   int n_err    = 0;

   // Frame-level model state
   logic [7:0] exp_a, exp_b, exp_tx;
   logic [5:0] exp_op;
   int         exp_start, exp_err;
   logic [5:0] legal_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};

   alu_uart_interface #(
      .N_BITS_DATA   (8),
      .N_BITS_OP     (6),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .rx_done_tick_i(rx_done_tick),
      .rx_data_i     (rx_data),
      .alu_result_i  (alu_result),
      .tx_done_tick_i(tx_done_tick),
      .data_a_o      (data_a),
      .data_b_o      (data_b),
      .op_o          (op),
      .tx_start_o    (tx_start),
      .tx_data_o     (tx_data),
      .frame_err_o   (frame_err),
      .busy_o        (busy)
   );

   assign alu_result = data_a + data_b;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (tx_start) n_start++;
      if (frame_err) n_err++;
   end

   function automatic bit is_legal(input logic [5:0] o);
      foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic tick(input logic [7:0] b);
      rx_data      = b;
      rx_done_tick = 1'b1;
      step();
      rx_done_tick = 1'b0;
   endtask

   task automatic send_a(input logic [7:0] b);
      tick(b);
      exp_a = b;
      chk("data_a", 32'(data_a), 32'(exp_a));
   endtask

   task automatic send_b(input logic [7:0] b);
      tick(b);
      exp_b = b;
      chk("data_b", 32'(data_b), 32'(exp_b));
   endtask

   task automatic send_op(input logic [7:0] b);
      logic [5:0] o;
      o = b[5:0];
      tick(b);
      if (is_legal(o)) begin
         exp_op = o;
         exp_tx = exp_a + exp_b;
         chk("op_valid", 32'(op), 32'(exp_op));
         chk("start_early", 32'(tx_start), 32'd0);
         chk("busy_exec", 32'(busy), 32'd1);
         step();
         chk("tx_start", 32'(tx_start), 32'd1);
         chk("tx_data", 32'(tx_data), 32'(exp_tx));
         step();
         exp_start++;
         chk("start_width", 32'(tx_start), 32'd0);
         chk("busy_wait_tx", 32'(busy), 32'd1);
         repeat (3) step();
         chk("busy_hold", 32'(busy), 32'd1);
         tx_done_tick = 1'b1;
         step();
         tx_done_tick = 1'b0;
         chk("busy_done", 32'(busy), 32'd0);
      end else begin
         chk("err_pulse", 32'(frame_err), 32'd1);
         chk("op_kept", 32'(op), 32'(exp_op));
         chk("busy_err", 32'(busy), 32'd0);
         step();
         exp_err++;
         chk("err_width", 32'(frame_err), 32'd0);
      end
      chk("start_count", 32'(n_start), 32'(exp_start));
      chk("err_count", 32'(n_err), 32'(exp_err));
   endtask

   initial begin
      logic [7:0] ra, rb, rop;
      reset        = 1'b0;
      rx_done_tick = 1'b0;
      rx_data      = '0;
      tx_done_tick = 1'b0;
      exp_a = '0; exp_b = '0; exp_op = '0; exp_tx = '0;
      exp_start = 0; exp_err = 0;
      repeat (3) step();
      chk("rst_a", 32'(data_a), 32'd0);
      chk("rst_b", 32'(data_b), 32'd0);
      chk("rst_op", 32'(op), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_start", 32'(tx_start), 32'd0);
      chk("rst_err", 32'(frame_err), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      step();

      // Basic ADD frame
      send_a(8'h07);
      send_b(8'h03);
      send_op(8'h20);
      chk("add_result", 32'(tx_data), 32'h0A);

      // tx_done outside WAIT_TX is ignored
      tx_done_tick = 1'b1;
      step();
      tx_done_tick = 1'b0;
      chk("txdone_idle_busy", 32'(busy), 32'd0);

      // Illegal opcode
      send_a(8'h05);
      send_b(8'h01);
      send_op(8'h3F);
      send_a(8'h11);

      // Timeout in WAIT_B after the A byte already taken above
      for (int i = 0; i < int'(T); i++) step();
      chk("to_no_early_err", 32'(n_err), 32'(exp_err));
      chk("to_err_pulse", 32'(frame_err), 32'd1);
      step();
      exp_err++;
      chk("to_err_width", 32'(frame_err), 32'd0);
      chk("to_b_stale", 32'(data_b), 32'(exp_b));
      send_a(8'h33);
      chk("to_a_not_b", 32'(data_b), 32'(exp_b));
      send_b(8'h44);
      send_op(8'h22);

      // Byte on the expiry cycle wins
      send_a(8'h22);
      for (int i = 0; i < int'(T) - 1; i++) step();
      send_b(8'h5A);
      chk("tie_no_err", 32'(n_err), 32'(exp_err));
      send_op(8'h24);

      // Extra rx byte during WAIT_TX is dropped
      send_a(8'h10);
      send_b(8'h20);
      tick(8'h20);
      exp_op = 6'h20;
      exp_tx = 8'h30;
      step();
      exp_start++;
      chk("wtx_data", 32'(tx_data), 32'(exp_tx));
      step();
      tick(8'h99);
      chk("wtx_a_kept", 32'(data_a), 32'(exp_a));
      chk("wtx_busy", 32'(busy), 32'd1);
      tx_done_tick = 1'b1;
      step();
      tx_done_tick = 1'b0;
      chk("wtx_err_count", 32'(n_err), 32'(exp_err));
      chk("wtx_start_count", 32'(n_start), 32'(exp_start));
      send_a(8'h66);

      // Asynchronous reset in WAIT_OP
      send_b(8'h55);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_a", 32'(data_a), 32'd0);
      chk("arst_b", 32'(data_b), 32'd0);
      chk("arst_op", 32'(op), 32'd0);
      chk("arst_tx_data", 32'(tx_data), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      exp_a = '0; exp_b = '0; exp_op = '0; exp_tx = '0;
      @(negedge clock);
      reset = 1'b1;
      step();
      send_a(8'h01);
      send_b(8'h02);
      send_op(8'h20);
      chk("arst_frame_tx", 32'(tx_data), 32'h03);

      // Random frames, mostly legal opcodes, random don't-care bits [7:6]
      for (int f = 0; f < 12; f++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if ($urandom_range(3) != 0) rop = {2'($urandom), legal_ops[$urandom_range(7)]};
         else begin
            rop = 8'($urandom);
            while (is_legal(rop[5:0])) rop = 8'($urandom);
         end
         send_a(ra);
         repeat ($urandom_range(5)) step();
         send_b(rb);
         repeat ($urandom_range(5)) step();
         send_op(rop);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
